// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation run/reset sequencer.
package sim_run_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } run_state_e;

    // Run outcome codes reported on fail_code
    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
    localparam logic [1:0] FAIL_STALL   = 2'b10;

    // MIPS encoding fields used to recognise `break`
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_BREAK = 6'h0D;

    // SPECIAL opcode with BREAK funct; the code field (bits 25:6) is ignored
    function automatic logic is_break(input logic [31:0] instr);
        return (instr[31:26] == OPC_SPECIAL) && (instr[5:0] == FUNCT_BREAK);
    endfunction

endpackage

// File: rtl/sim_run_stall_det.sv
// PC stall detector: counts consecutive RUN cycles in which the sampled PC
// repeats the previous RUN cycle's PC, and flags a stall on the cycle that
// completes STALL_LIMIT equal samples.
module sim_run_stall_det #(
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [31:0] i_pc,
    output logic        o_stall
);

    localparam int unsigned CntW = $clog2(STALL_LIMIT) + 1;
    // Repeat count already held when the current repeat is the final one
    localparam logic [CntW-1:0] RepeatLast = CntW'(STALL_LIMIT - 2);

    logic [31:0]     r_prev_pc;
    logic            r_prev_valid;
    logic [CntW-1:0] r_rep_cnt;
    logic            w_repeat;

    // Compare the current PC against the previous RUN-cycle sample
    always_comb begin
        w_repeat = i_run && r_prev_valid && (i_pc == r_prev_pc);
        o_stall  = w_repeat && (r_rep_cnt == RepeatLast);
    end

    // Track previous PC and repeat run length; history is dropped outside RUN
    // so the first RUN cycle never counts as a repeat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (i_run) begin
            r_prev_pc    <= i_pc;
            r_prev_valid <= 1'b1;
            r_rep_cnt    <= w_repeat ? (r_rep_cnt + CntW'(1)) : '0;
        end else begin
            r_prev_valid <= 1'b0;
            r_rep_cnt    <= '0;
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run/reset sequencer for the MIPS core simulation harness. Holds the core in
// reset for RESET_CYCLES after start, counts run cycles and ends the run on a
// `break`, a timeout, or (with SIM_RUN_STALL_DETECT_EN defined) a PC stall.
module sim_run_controller
    import sim_run_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned STALL_LIMIT    = 8,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr_in,
    output logic             core_reset,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code
);

    localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STALL_LIMIT < 2) begin : g_param_check
        $error("sim_run_controller: parameter out of range");
    end

    run_state_e       r_state;
    run_state_e       w_state_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_pass;
    logic [1:0]       r_fail_code;

    logic w_in_run;
    logic w_hold_last;
    logic w_break;
    logic w_timeout;
    logic w_stall;
    logic w_finish;
    logic w_accept_start;

    // Termination conditions and control decodes
    always_comb begin
        w_in_run       = (r_state == StRun);
        w_hold_last    = (r_state == StHold) && (r_hold_cnt == HoldLast);
        w_break        = w_in_run && is_break(instr_in);
        w_timeout      = w_in_run && (r_cycle_count == TimeoutLast);
        w_finish       = w_break || w_timeout || w_stall;
        w_accept_start = start && ((r_state == StIdle) || (r_state == StDone));
    end

`ifdef SIM_RUN_STALL_DETECT_EN
    sim_run_stall_det #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_det (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_run   (w_in_run),
        .i_pc    (pc_in),
        .o_stall (w_stall)
    );
`else
    assign w_stall = 1'b0;
    logic w_unused_pc;
    assign w_unused_pc = ^pc_in;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_next = StHold;
            StHold: if (w_hold_last) w_state_next = StRun;
            StRun:  if (w_finish) w_state_next = StDone;
            StDone: if (start) w_state_next = StHold;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state; core_reset follows the async state reset
    always_comb begin
        core_reset = 1'b1;
        running    = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            StIdle: core_reset = 1'b1;
            StHold: core_reset = 1'b1;
            StRun: begin
                core_reset = 1'b0;
                running    = 1'b1;
            end
            StDone: done = 1'b1;
            default: core_reset = 1'b1;
        endcase
        cycle_count = r_cycle_count;
        pass        = r_pass;
        fail_code   = r_fail_code;
    end

    // HOLD cycle counter; idles at zero so each HOLD starts from a clean count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if ((r_state == StHold) && !w_hold_last) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // Run cycle counter: cleared on start, saturating, frozen on the exit edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else if (w_accept_start) begin
            r_cycle_count <= '0;
        end else if (w_in_run && !w_finish && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    // Run outcome: captured on the exit edge with break > timeout > stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pass      <= 1'b0;
            r_fail_code <= FAIL_NONE;
        end else if (w_accept_start) begin
            r_pass      <= 1'b0;
            r_fail_code <= FAIL_NONE;
        end else if (w_in_run && w_finish) begin
            r_pass <= w_break;
            if (w_break) begin
                r_fail_code <= FAIL_NONE;
            end else if (w_timeout) begin
                r_fail_code <= FAIL_TIMEOUT;
            end else begin
                r_fail_code <= FAIL_STALL;
            end
        end
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller. Build with +define+SIM_RUN_STALL_DETECT_EN to
// exercise the stall detector; expectations follow the same macro.
module tb_sim_run_controller;

    localparam int unsigned ResetCycles   = 2;
    localparam int unsigned TimeoutCycles = 100;
    localparam int unsigned StallLimit    = 8;
    localparam int unsigned CntW          = 32;
`ifdef SIM_RUN_STALL_DETECT_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [31:0]     pc_in;
    logic [31:0]     instr_in;
    logic            core_reset;
    logic            running;
    logic [CntW-1:0] cycle_count;
    logic            done;
    logic            pass;
    logic [1:0]      fail_code;

    int checks = 0;
    int passed = 0;

    // Per-RUN-cycle stimulus and the expected outcome of the run
    logic [31:0] pc_a  [TimeoutCycles];
    logic [31:0] ins_a [TimeoutCycles];
    int          exp_end;
    bit          exp_pass;
    logic [1:0]  exp_code;

    always #5 clock = ~clock;

    sim_run_controller #(
        .RESET_CYCLES   (ResetCycles),
        .TIMEOUT_CYCLES (TimeoutCycles),
        .STALL_LIMIT    (StallLimit),
        .CNT_W          (CntW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .core_reset  (core_reset),
        .running     (running),
        .cycle_count (cycle_count),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code)
    );

    function automatic bit ref_is_break(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (w[5:0] == 6'd13);
    endfunction

    function automatic logic [31:0] rand_nonbreak();
        logic [31:0] r;
        r = $urandom;
        if (ref_is_break(r)) r[0] = 1'b0;
        return r;
    endfunction

    // Reference: walk the run cycle by cycle, first matching rule ends it
    task automatic compute_expected();
        int  runlen;
        bit  found;
        runlen   = 0;
        found    = 0;
        exp_end  = TimeoutCycles - 1;
        exp_pass = 0;
        exp_code = 2'b01;
        for (int k = 0; k < TimeoutCycles; k++) begin
            if (!found) begin
                runlen = (k > 0 && pc_a[k] == pc_a[k-1]) ? runlen + 1 : 1;
                if (ref_is_break(ins_a[k])) begin
                    found = 1; exp_end = k; exp_pass = 1; exp_code = 2'b00;
                end else if (k == TimeoutCycles - 1) begin
                    found = 1; exp_end = k; exp_pass = 0; exp_code = 2'b01;
                end else if (StallEn && runlen >= StallLimit) begin
                    found = 1; exp_end = k; exp_pass = 0; exp_code = 2'b10;
                end
            end
        end
    endtask

    // Monotonic PC, no breaks except an optional one at brk_at
    task automatic fill_plain(input int brk_at, input logic [31:0] brk_word);
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        for (int k = 0; k < TimeoutCycles; k++) begin
            pc_a[k]  = base + 32'(4 * k);
            ins_a[k] = (k == brk_at) ? brk_word : rand_nonbreak();
        end
    endtask

    // PC with random repeat runs and sparse random breaks
    task automatic fill_random();
        logic [31:0] p;
        p = $urandom & 32'hFFFF_FFFC;
        for (int k = 0; k < TimeoutCycles; k++) begin
            if (k > 0 && $urandom_range(0, 9) >= 4) p = p + 32'd4;
            pc_a[k] = p;
            if ($urandom_range(0, 59) == 0)
                ins_a[k] = {6'd0, 20'($urandom), 6'h0D};
            else
                ins_a[k] = rand_nonbreak();
        end
    endtask

    // One full run: start pulse, HOLD, RUN against the model, DONE freeze.
    // abort_at >= 0 drops async reset mid-cycle in that RUN cycle instead.
    task automatic run_once(input string name, input int abort_at, input bit noisy_start);
        compute_expected();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int h = 0; h < ResetCycles; h++) begin
            checks++;
            if ({core_reset, running, done, pass, fail_code, cycle_count} !== {6'b100000, CntW'(0)})
                $display("FAIL %s hold[%0d]: got cr=%b run=%b done=%b pass=%b fc=%b cnt=%0d, want cr=1 run=0 done=0 pass=0 fc=00 cnt=0",
                         name, h, core_reset, running, done, pass, fail_code, cycle_count);
            else passed++;
            @(posedge clock); #1;
        end
        for (int k = 0; k <= exp_end; k++) begin
            checks++;
            if ({core_reset, running, done, cycle_count} !== {3'b010, CntW'(k)})
                $display("FAIL %s run[%0d]: got cr=%b run=%b done=%b cnt=%0d, want cr=0 run=1 done=0 cnt=%0d",
                         name, k, core_reset, running, done, cycle_count, k);
            else passed++;
            pc_in    = pc_a[k];
            instr_in = ins_a[k];
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                checks++;
                if ({core_reset, running, done, pass, fail_code, cycle_count} !== {6'b100000, CntW'(0)})
                    $display("FAIL %s async_reset: got cr=%b run=%b done=%b pass=%b fc=%b cnt=%0d, want cr=1 run=0 done=0 pass=0 fc=00 cnt=0",
                             name, core_reset, running, done, pass, fail_code, cycle_count);
                else passed++;
                @(posedge clock); #1;
                reset = 1'b1;
                start = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                checks++;
                if ({core_reset, running, done, cycle_count} !== {3'b100, CntW'(0)})
                    $display("FAIL %s idle_after_reset: got cr=%b run=%b done=%b cnt=%0d, want cr=1 run=0 done=0 cnt=0",
                             name, core_reset, running, done, cycle_count);
                else passed++;
                return;
            end
            if (noisy_start) start = ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
        end
        start = 1'b0;
        checks++;
        if ({core_reset, running, done, pass, fail_code, cycle_count} !==
            {3'b101, exp_pass, exp_code, CntW'(exp_end)})
            $display("FAIL %s end: got cr=%b run=%b done=%b pass=%b fc=%b cnt=%0d, want cr=1 run=0 done=1 pass=%b fc=%b cnt=%0d",
                     name, core_reset, running, done, pass, fail_code, cycle_count,
                     exp_pass, exp_code, exp_end);
        else passed++;
        // DONE must ignore further breaks and PC activity
        for (int f = 0; f < 3; f++) begin
            instr_in = (f == 0) ? 32'h0000000D : rand_nonbreak();
            pc_in    = $urandom;
            @(posedge clock); #1;
            checks++;
            if ({done, pass, fail_code, cycle_count} !== {1'b1, exp_pass, exp_code, CntW'(exp_end)})
                $display("FAIL %s freeze[%0d]: got done=%b pass=%b fc=%b cnt=%0d, want done=1 pass=%b fc=%b cnt=%0d",
                         name, f, done, pass, fail_code, cycle_count, exp_pass, exp_code, exp_end);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        pc_in    = '0;
        instr_in = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            checks++;
            if ({core_reset, running, done, pass, fail_code, cycle_count} !== {6'b100000, CntW'(0)})
                $display("FAIL reset idle[%0d]: got cr=%b run=%b done=%b pass=%b fc=%b cnt=%0d, want cr=1 run=0 done=0 pass=0 fc=00 cnt=0",
                         c, core_reset, running, done, pass, fail_code, cycle_count);
            else passed++;
        end
    endtask

    task automatic test_break();
        fill_plain(5, 32'h0000000D);
        run_once("break", -1, 1'b0);
    endtask

    task automatic test_timeout_restart();
        fill_plain(-1, 32'h0);
        run_once("timeout", -1, 1'b0);
        fill_plain($urandom_range(0, TimeoutCycles - 2), {6'd0, 20'($urandom), 6'h0D});
        run_once("restart", -1, 1'b0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < TimeoutCycles; k++) begin
            pc_a[k]  = (k < 3) ? 32'(4 * k) : 32'd8;
            ins_a[k] = rand_nonbreak();
        end
        run_once("stall", -1, 1'b0);
        // Runs of StallLimit-1 equal samples must never trip the detector
        for (int k = 0; k < TimeoutCycles; k++) begin
            pc_a[k]  = 32'h400 + 32'(4 * (k / (StallLimit - 1)));
            ins_a[k] = rand_nonbreak();
        end
        run_once("stall_boundary", -1, 1'b0);
    endtask

    task automatic test_break_vs_timeout();
        fill_plain(TimeoutCycles - 1, 32'h0000000D);
        run_once("break_at_timeout", -1, 1'b0);
    endtask

    task automatic test_async_reset();
        fill_plain(-1, 32'h0);
        run_once("abort", 10, 1'b0);
        fill_plain(20, {6'd0, 20'($urandom), 6'h0D});
        run_once("after_abort", -1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_once("random", -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_break();
        test_timeout_restart();
        test_stall();
        test_break_vs_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
